gsu_mmio_wr: RTL and testbench

GSU_MMIO_WR -- requirements
Module: gsu_mmio_wr

---
 rtl/gsu_mmio_wr.sv | 132 +++++++++++++
 tb/tb_gsu_mmio_wr.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gsu_mmio_wr.sv
// gsu_mmio_wr: decodes SNES writes into GSU registers, control/config registers and cache RAM.
// Revision 1.0 - initial release.
`default_nettype none

module gsu_mmio_wr (
  input  logic        clkin,
  input  logic        rst,
  input  logic [23:0] ADDR,
  input  logic [7:0]  DI,
  input  logic        CS,
  input  logic        reg_we_rising,
  input  logic        gsu_running,
  input  logic        cache_flush,
  output logic        reg_wr_stb,
  output logic [3:0]  reg_wr_idx,
  output logic [15:0] reg_wr_data,
  output logic        go_pulse,
  output logic        stop_pulse,
  output logic        bramr,
  output logic [7:0]  pbr,
  output logic [7:0]  cfgr,
  output logic [7:0]  scbr,
  output logic        clsr,
  output logic [5:0]  scmr,
  output logic        cache_wr_en,
  output logic [8:0]  cache_wr_addr,
  output logic [7:0]  cache_wr_data,
  output logic [31:0] cache_valid,
  output logic [7:0]  drop_cnt
);

  logic        wr_ev;
  logic        is_ctrl;
  logic        is_gpr;
  logic        is_cache;
  logic        accept;
  logic        drop;
  logic [8:0]  cache_off;
  logic [31:0] valid_set;
  logic [7:0]  latch;
  logic        unused_addr;

  assign unused_addr = ^{ADDR[23], ADDR[21:16]};

  assign wr_ev    = CS & ~ADDR[22] & (ADDR[15:12] == 4'h3) &
                    (ADDR[15:0] < 16'h3300) & reg_we_rising;
  assign is_ctrl  = (ADDR[15:0] == 16'h3030);
  assign is_gpr   = (ADDR[15:5] == 11'h180);
  assign is_cache = (ADDR[15:8] == 8'h31) | (ADDR[15:8] == 8'h32);

  // Only the go/stop register stays writable while the core runs.
  assign accept = wr_ev & (~gsu_running | is_ctrl);
  assign drop   = wr_ev & gsu_running & ~is_ctrl;

  // ADDR[9:0]-'h100 over $100-$2FF: low byte unchanged, bit 8 becomes ADDR[9].
  assign cache_off = {ADDR[9], ADDR[7:0]};

  always_comb begin
    valid_set = 32'h0;
    if (accept && is_cache && (cache_off[3:0] == 4'hF))
      valid_set[cache_off[8:4]] = 1'b1;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      latch         <= 8'h00;
      reg_wr_stb    <= 1'b0;
      reg_wr_idx    <= 4'h0;
      reg_wr_data   <= 16'h0000;
      go_pulse      <= 1'b0;
      stop_pulse    <= 1'b0;
      bramr         <= 1'b0;
      pbr           <= 8'h00;
      cfgr          <= 8'h00;
      scbr          <= 8'h00;
      clsr          <= 1'b0;
      scmr          <= 6'h00;
      cache_wr_en   <= 1'b0;
      cache_wr_addr <= 9'h000;
      cache_wr_data <= 8'h00;
      cache_valid   <= 32'h0;
      drop_cnt      <= 8'h00;
    end else begin
      reg_wr_stb  <= 1'b0;
      go_pulse    <= 1'b0;
      stop_pulse  <= 1'b0;
      cache_wr_en <= 1'b0;

      if (accept && is_gpr) begin
        if (!ADDR[0]) begin
          latch <= DI;
        end else begin
          reg_wr_stb  <= 1'b1;
          reg_wr_idx  <= ADDR[4:1];
          reg_wr_data <= {DI, latch};
          go_pulse    <= (ADDR[4:1] == 4'hF);
        end
      end

      if (accept && (ADDR[15:8] == 8'h30) && !is_gpr) begin
        case (ADDR[7:0])
          8'h30: begin
            go_pulse   <= DI[5];
            stop_pulse <= ~DI[5] & gsu_running;
          end
          8'h33:   bramr <= DI[0];
          8'h34:   pbr   <= DI;
          8'h37:   cfgr  <= DI;
          8'h38:   scbr  <= DI;
          8'h39:   clsr  <= DI[0];
          8'h3A:   scmr  <= DI[5:0];
          default: ;
        endcase
      end

      if (accept && is_cache) begin
        cache_wr_en   <= 1'b1;
        cache_wr_addr <= cache_off;
        cache_wr_data <= DI;
      end

      // Flush clears first; a line completed in the same cycle survives.
      cache_valid <= (cache_flush ? 32'h0 : cache_valid) | valid_set;

      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gsu_mmio_wr.sv
// tb_gsu_mmio_wr: directed self-checking bench for gsu_mmio_wr.
`default_nettype none

module tb_gsu_mmio_wr;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] ADDR = 24'h0;
  logic [7:0]  DI = 8'h0;
  logic        CS = 1'b0;
  logic        reg_we_rising = 1'b0;
  logic        gsu_running = 1'b0;
  logic        cache_flush = 1'b0;
  logic        reg_wr_stb;
  logic [3:0]  reg_wr_idx;
  logic [15:0] reg_wr_data;
  logic        go_pulse;
  logic        stop_pulse;
  logic        bramr;
  logic [7:0]  pbr;
  logic [7:0]  cfgr;
  logic [7:0]  scbr;
  logic        clsr;
  logic [5:0]  scmr;
  logic        cache_wr_en;
  logic [8:0]  cache_wr_addr;
  logic [7:0]  cache_wr_data;
  logic [31:0] cache_valid;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clkin = ~clkin;

  gsu_mmio_wr dut (
    .clkin(clkin), .rst(rst), .ADDR(ADDR), .DI(DI), .CS(CS),
    .reg_we_rising(reg_we_rising), .gsu_running(gsu_running), .cache_flush(cache_flush),
    .reg_wr_stb(reg_wr_stb), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .go_pulse(go_pulse), .stop_pulse(stop_pulse), .bramr(bramr), .pbr(pbr),
    .cfgr(cfgr), .scbr(scbr), .clsr(clsr), .scmr(scmr), .cache_wr_en(cache_wr_en),
    .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .cache_valid(cache_valid), .drop_cnt(drop_cnt)
  );

  // Drive one strobed cycle; returns at the following negedge so outputs show its effect.
  task automatic wr(input logic [23:0] a, input logic [7:0] d, input logic c, input logic fl);
    @(negedge clkin);
    ADDR = a; DI = d; CS = c; cache_flush = fl; reg_we_rising = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    reg_we_rising = 1'b0; CS = 1'b0; cache_flush = 1'b0;
  endtask

  task automatic w(input logic [23:0] a, input logic [7:0] d);
    wr(a, d, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clkin);
    n_cmp++; if ({reg_wr_stb, go_pulse, stop_pulse, cache_wr_en} !== 4'b0) begin n_err++; $display("FAIL reset_pulses got %b want 0000", {reg_wr_stb, go_pulse, stop_pulse, cache_wr_en}); end
    n_cmp++; if ({bramr, pbr, cfgr, scbr, clsr, scmr} !== 32'h0) begin n_err++; $display("FAIL reset_cfg got %h want 0", {bramr, pbr, cfgr, scbr, clsr, scmr}); end
    n_cmp++; if ({cache_valid, drop_cnt} !== 40'h0) begin n_err++; $display("FAIL reset_valid_drop got %h want 0", {cache_valid, drop_cnt}); end
    rst = 1'b0;
  endtask

  task automatic test_commit;
    w(24'h003004, 8'h34);
    n_cmp++; if (reg_wr_stb !== 1'b0) begin n_err++; $display("FAIL even_no_stb got %b want 0", reg_wr_stb); end
    w(24'h003005, 8'h12);
    n_cmp++; if ({reg_wr_stb, reg_wr_idx, reg_wr_data, go_pulse} !== {1'b1, 4'h2, 16'h1234, 1'b0}) begin
      n_err++; $display("FAIL commit_r2 got stb=%b idx=%h data=%h go=%b want 1 2 1234 0", reg_wr_stb, reg_wr_idx, reg_wr_data, go_pulse); end
    @(negedge clkin);
    n_cmp++; if (reg_wr_stb !== 1'b0) begin n_err++; $display("FAIL stb_one_cycle got %b want 0", reg_wr_stb); end
    w(24'h003009, 8'h56);
    n_cmp++; if ({reg_wr_stb, reg_wr_idx, reg_wr_data} !== {1'b1, 4'h4, 16'h5634}) begin
      n_err++; $display("FAIL latch_persist got stb=%b idx=%h data=%h want 1 4 5634", reg_wr_stb, reg_wr_idx, reg_wr_data); end
  endtask

  task automatic test_go_commit;
    w(24'h00301E, 8'h00);
    w(24'h00301F, 8'h80);
    n_cmp++; if ({reg_wr_stb, reg_wr_idx, reg_wr_data, go_pulse} !== {1'b1, 4'hF, 16'h8000, 1'b1}) begin
      n_err++; $display("FAIL commit_r15_go got stb=%b idx=%h data=%h go=%b want 1 f 8000 1", reg_wr_stb, reg_wr_idx, reg_wr_data, go_pulse); end
  endtask

  task automatic test_ctrl_cfg;
    w(24'h003030, 8'h20);
    n_cmp++; if ({go_pulse, stop_pulse} !== 2'b10) begin n_err++; $display("FAIL ctrl_go got %b want 10", {go_pulse, stop_pulse}); end
    w(24'h003030, 8'h00);
    n_cmp++; if ({go_pulse, stop_pulse} !== 2'b00) begin n_err++; $display("FAIL ctrl_stop_idle got %b want 00", {go_pulse, stop_pulse}); end
    w(24'h003033, 8'hFF); w(24'h003034, 8'h7E); w(24'h003037, 8'hA5);
    w(24'h003038, 8'h3C); w(24'h003039, 8'h03); w(24'h00303A, 8'hFF);
    n_cmp++; if ({bramr, pbr, cfgr, scbr, clsr, scmr} !== {1'b1, 8'h7E, 8'hA5, 8'h3C, 1'b1, 6'h3F}) begin
      n_err++; $display("FAIL cfg_write got %h want %h", {bramr, pbr, cfgr, scbr, clsr, scmr}, {1'b1, 8'h7E, 8'hA5, 8'h3C, 1'b1, 6'h3F}); end
    w(24'h003035, 8'h11); w(24'h003031, 8'h22);
    wr(24'h003034, 8'h11, 1'b0, 1'b0);
    w(24'h403034, 8'h11);
    w(24'h003300, 8'h11);
    n_cmp++; if ({bramr, pbr, cfgr, scbr, clsr, scmr} !== {1'b1, 8'h7E, 8'hA5, 8'h3C, 1'b1, 6'h3F}) begin
      n_err++; $display("FAIL cfg_ignored got %h want %h", {bramr, pbr, cfgr, scbr, clsr, scmr}, {1'b1, 8'h7E, 8'hA5, 8'h3C, 1'b1, 6'h3F}); end
    n_cmp++; if (cache_valid !== 32'h0) begin n_err++; $display("FAIL addr3300_ignored got %h want 0", cache_valid); end
  endtask

  task automatic test_cache;
    for (int i = 0; i < 16; i++) begin
      w(24'h003100 + 24'(i), 8'(8'hC0 + i));
      n_cmp++; if ({cache_wr_en, cache_wr_addr, cache_wr_data} !== {1'b1, 9'(i), 8'(8'hC0 + i)}) begin
        n_err++; $display("FAIL cache_wr[%0d] got en=%b addr=%h data=%h", i, cache_wr_en, cache_wr_addr, cache_wr_data); end
      n_cmp++; if (cache_valid !== ((i == 15) ? 32'h1 : 32'h0)) begin
        n_err++; $display("FAIL cache_valid[%0d] got %h want %h", i, cache_valid, (i == 15) ? 32'h1 : 32'h0); end
    end
    w(24'h0032FF, 8'h5A);
    n_cmp++; if ({cache_wr_addr, cache_wr_data, cache_valid} !== {9'h1FF, 8'h5A, 32'h8000_0001}) begin
      n_err++; $display("FAIL cache_top got addr=%h data=%h valid=%h want 1ff 5a 80000001", cache_wr_addr, cache_wr_data, cache_valid); end
  endtask

  task automatic test_running;
    gsu_running = 1'b1;
    w(24'h003000, 8'h77);
    n_cmp++; if ({reg_wr_stb, go_pulse, stop_pulse, cache_wr_en} !== 4'b0) begin n_err++; $display("FAIL run_drop_gpr got %b want 0000", {reg_wr_stb, go_pulse, stop_pulse, cache_wr_en}); end
    w(24'h003110, 8'h77);
    n_cmp++; if ({cache_wr_en, drop_cnt} !== {1'b0, 8'd2}) begin n_err++; $display("FAIL run_drop_cnt got en=%b cnt=%0d want 0 2", cache_wr_en, drop_cnt); end
    w(24'h003030, 8'h00);
    n_cmp++; if ({go_pulse, stop_pulse} !== 2'b01) begin n_err++; $display("FAIL run_stop got %b want 01", {go_pulse, stop_pulse}); end
    w(24'h003030, 8'h20);
    n_cmp++; if ({go_pulse, stop_pulse, drop_cnt} !== {2'b10, 8'd2}) begin n_err++; $display("FAIL run_go got %b cnt=%0d want 10 2", {go_pulse, stop_pulse}, drop_cnt); end
    gsu_running = 1'b0;
    w(24'h003003, 8'h99);
    n_cmp++; if ({reg_wr_stb, reg_wr_idx, reg_wr_data} !== {1'b1, 4'h1, 16'h9900}) begin
      n_err++; $display("FAIL run_latch_kept got stb=%b idx=%h data=%h want 1 1 9900", reg_wr_stb, reg_wr_idx, reg_wr_data); end
  endtask

  task automatic test_saturate;
    gsu_running = 1'b1;
    for (int i = 0; i < 260; i++) w(24'h003020, 8'h00);
    gsu_running = 1'b0;
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_err++; $display("FAIL drop_saturate got %h want ff", drop_cnt); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 32; k++) w(24'h00310F + 24'(k * 16), 8'h00);
    n_cmp++; if (cache_valid !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL valid_all got %h want ffffffff", cache_valid); end
    wr(24'h0031FF, 8'h01, 1'b1, 1'b1);
    n_cmp++; if (cache_valid !== 32'h0000_8000) begin n_err++; $display("FAIL flush_with_write got %h want 00008000", cache_valid); end
    wr(24'h0031FF, 8'h01, 1'b0, 1'b1);
    n_cmp++; if (cache_valid !== 32'h0) begin n_err++; $display("FAIL flush_only got %h want 0", cache_valid); end
  endtask

  task automatic test_reset_mid;
    w(24'h003006, 8'hAA);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({pbr, drop_cnt, reg_wr_data} !== 32'h0) begin n_err++; $display("FAIL async_reset got %h want 0", {pbr, drop_cnt, reg_wr_data}); end
    @(negedge clkin);
    rst = 1'b0;
    w(24'h003007, 8'hBB);
    n_cmp++; if ({reg_wr_stb, reg_wr_idx, reg_wr_data} !== {1'b1, 4'h3, 16'hBB00}) begin
      n_err++; $display("FAIL reset_mid_commit got stb=%b idx=%h data=%h want 1 3 bb00", reg_wr_stb, reg_wr_idx, reg_wr_data); end
  endtask

  initial begin
    test_reset;
    test_commit;
    test_go_commit;
    test_ctrl_cfg;
    test_cache;
    test_running;
    test_saturate;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
